// File: rtl/shift_rows_pipe_if.sv
// shift_rows_pipe_if: valid/ready bus for the ShiftRows pipeline.
//   in_valid/in_ready/in_mode/state_in : upstream state transfer (mode 0 fwd, 1 inv)
//   out_valid/out_ready/state_out      : downstream state transfer
//   master : the side that produces input states and consumes results
//   slave  : the ShiftRows pipeline itself
interface shift_rows_pipe_if #(
    parameter int unsigned NB = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [32*NB-1:0]  state_in;
    logic              out_valid;
    logic              out_ready;
    logic [32*NB-1:0]  state_out;

    modport master (
        output in_valid, in_mode, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, in_mode, state_in, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined AES/Rijndael forward/inverse ShiftRows.
//   NB     : state columns (4, 6 or 8)
//   STAGES : register stages (1..4)
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears valid bits and data
//   flush     : synchronous clear of all in-flight states
//   bus       : valid/ready input and output state transfers (slave side)
//   occupancy : number of valid stages
module shift_rows_pipe #(
    parameter int unsigned NB     = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    shift_rows_pipe_if.slave             bus,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);
    localparam int unsigned W     = 32 * NB;
    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be in 1..4");
    end

    // Rijndael row offsets: 0,1,2,3 for NB 4/6; 0,1,3,4 for NB 8.
    function automatic int unsigned row_shift(input int unsigned r);
        if (NB == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    logic [W-1:0]      shifted;
    logic [W-1:0]      data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] adv;
    logic              stage0_free;
    logic              accept;

    // Byte permutation; only column indices are rotated.
    always_comb begin
        int unsigned src;
        shifted = '0;
        src     = 0;
        for (int unsigned c = 0; c < NB; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                if (bus.in_mode) src = (c + NB - row_shift(r)) % NB;
                else             src = (c + row_shift(r)) % NB;
                shifted[32*c + 8*r +: 8] = bus.state_in[32*src + 8*r +: 8];
            end
        end
    end

    // Advance chain evaluated from the output stage backwards so a stage
    // may refill in the same cycle its successor drains.
    always_comb begin
        logic        nxt;
        int unsigned idx;
        adv          = '0;
        idx          = 0;
        nxt          = valid_q[STAGES-1] && bus.out_ready;
        adv[STAGES-1] = nxt;
        for (int unsigned k = 1; k < STAGES; k++) begin
            idx      = STAGES - 1 - k;
            nxt      = valid_q[idx] && (!valid_q[idx+1] || nxt);
            adv[idx] = nxt;
        end
    end

    assign stage0_free  = !valid_q[0] || adv[0];
    assign bus.in_ready = rst_n && !flush && stage0_free;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d    = '0;
        valid_d[0] = accept || (valid_q[0] && !adv[0]);
        for (int unsigned k = 1; k < STAGES; k++) begin
            valid_d[k] = adv[k-1] || (valid_q[k] && !adv[k]);
        end
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) data_q[0] <= shifted;
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (adv[k-1]) data_q[k] <= data_q[k-1];
            end
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.state_out = data_q[STAGES-1];

    always_comb begin
        occupancy = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: scoreboard bench for shift_rows_pipe.
// Three instances: NB=4/STAGES=2, NB=8/STAGES=4, NB=6/STAGES=1.
module tb_shift_rows_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       flush4;
    logic [1:0] occ4;
    logic [2:0] occ8;
    logic [0:0] occ6;

    shift_rows_pipe_if #(.NB(4)) b4 ();
    shift_rows_pipe_if #(.NB(8)) b8 ();
    shift_rows_pipe_if #(.NB(6)) b6 ();

    shift_rows_pipe #(.NB(4), .STAGES(2)) u4 (
        .clk(clk), .rst_n(rst_n), .flush(flush4), .bus(b4.slave), .occupancy(occ4));
    shift_rows_pipe #(.NB(8), .STAGES(4)) u8 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .bus(b8.slave), .occupancy(occ8));
    shift_rows_pipe #(.NB(6), .STAGES(1)) u6 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .bus(b6.slave), .occupancy(occ6));

    localparam logic [127:0] V4 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] F4 = 128'h0b06010c_07020d08_030e0904_0f0a0500;
    localparam logic [127:0] I4 = 128'h0306090c_0f020508_0b0e0104_070a0d00;
    localparam logic [255:0] V8 = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [255:0] F8 = 256'h0f0a011c_0b061d18_07021914_031e1510_1f1a110c_1b160d08_17120904_130e0500;
    localparam logic [255:0] I8 = 256'h0f12191c_0b0e1518_070a1114_03060d10_1f02090c_1b1e0508_171a0104_13161d00;

    logic [255:0] q4 [$];
    logic [255:0] q8 [$];
    logic [255:0] q6 [$];
    int unsigned  checks   = 0;
    int unsigned  failures = 0;
    bit           done     = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference: rotate each row left one column at a time; inverse is a
    // left rotation by NB - s.
    function automatic logic [255:0] ref_shift(input int nb, input logic inv, input logic [255:0] s);
        logic [7:0]   row [8];
        logic [7:0]   tmp;
        logic [255:0] o;
        int           sh;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            sh = (nb == 8 && r >= 2) ? r + 1 : r;
            if (inv) sh = nb - sh;
            for (int c = 0; c < nb; c++) row[c] = s[32*c + 8*r +: 8];
            for (int k = 0; k < sh; k++) begin
                tmp = row[0];
                for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
                row[nb-1] = tmp;
            end
            for (int c = 0; c < nb; c++) o[32*c + 8*r +: 8] = row[c];
        end
        return o;
    endfunction

    function automatic logic [255:0] rand_state(input int nb);
        logic [255:0] s;
        s = '0;
        for (int w = 0; w < nb; w++) s[32*w +: 32] = $urandom;
        return s;
    endfunction

    task automatic drive(input int which, input logic v, input logic m, input logic [255:0] d);
        case (which)
            4: begin b4.in_valid = v; b4.in_mode = m; b4.state_in = d[127:0]; end
            8: begin b8.in_valid = v; b8.in_mode = m; b8.state_in = d; end
            default: begin b6.in_valid = v; b6.in_mode = m; b6.state_in = d[191:0]; end
        endcase
    endtask

    task automatic idle(input int which);
        drive(which, 1'b0, 1'b0, '0);
    endtask

    function automatic logic rdy(input int which);
        case (which)
            4:       return b4.in_ready;
            8:       return b8.in_ready;
            default: return b6.in_ready;
        endcase
    endfunction

    function automatic logic ovalid(input int which);
        case (which)
            4:       return b4.out_valid;
            8:       return b8.out_valid;
            default: return b6.out_valid;
        endcase
    endfunction

    function automatic int unsigned qsize(input int which);
        case (which)
            4:       return q4.size();
            8:       return q8.size();
            default: return q6.size();
        endcase
    endfunction

    task automatic push(input int which, input logic [255:0] e);
        case (which)
            4:       q4.push_back(e);
            8:       q8.push_back(e);
            default: q6.push_back(e);
        endcase
    endtask

    // Offer a state until accepted (bounded); expectation queued on accept.
    task automatic send(input int which, input logic m, input logic [255:0] d, input logic [255:0] e);
        bit ok;
        ok = 1'b0;
        drive(which, 1'b1, m, d);
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = rdy(which);
        end
        if (ok) push(which, e);
        else chk($sformatf("send%0d_timeout", which), 256'(ok), 256'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int which);
        int n;
        n = 0;
        while (qsize(which) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain%0d", which), 256'(qsize(which)), 256'(0));
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge: number of negedges until out_valid.
    task automatic latency(input int which, input int exp_neg);
        int got;
        got = 0;
        for (int n = 1; n <= 10 && got == 0; n++) begin
            @(negedge clk);
            if (ovalid(which)) got = n;
        end
        chk($sformatf("latency%0d", which), 256'(got), 256'(exp_neg));
        @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp(input int which, input logic [255:0] act);
        logic [255:0] e;
        if (qsize(which) == 0) begin
            checks++;
            failures++;
            $display("FAIL out%0d_unexpected: got %h required no output", which, act);
        end else begin
            case (which)
                4:       e = q4.pop_front();
                8:       e = q8.pop_front();
                default: e = q6.pop_front();
            endcase
            chk($sformatf("out%0d", which), act, e);
        end
    endtask

    task automatic monitor();
        int unsigned cyc;
        cyc = 0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                checks++;
                failures++;
                $display("FAIL watchdog: got %0d cycles required below 20000", cyc);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "watchdog expired");
            end
            if (rst_n === 1'b1) begin
                if (b4.out_valid && b4.out_ready) pop_cmp(4, 256'(b4.state_out));
                if (b8.out_valid && b8.out_ready) pop_cmp(8, b8.state_out);
                if (b6.out_valid && b6.out_ready) pop_cmp(6, 256'(b6.state_out));
            end
        end
    endtask

    task automatic stimulus();
        logic [255:0] x, y;
        logic         bm [4];
        logic [255:0] be [4];
        int           j;
        longint       t0;

        rst_n = 1'b1; flush4 = 1'b0;
        idle(4); idle(8); idle(6);
        b4.out_ready = 1'b1; b8.out_ready = 1'b1; b6.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 256'(b4.in_ready), 256'(0));
        chk("rst_out_valid", 256'(b4.out_valid), 256'(0));
        chk("rst_occupancy", 256'(occ4), 256'(0));
        chk("rst_state_out", 256'(b4.state_out), 256'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 256'(b4.in_ready), 256'(1));

        // Forward and inverse directed vectors with latency.
        send(4, 1'b0, 256'(V4), 256'(F4));
        idle(4);
        chk("occ_one", 256'(occ4), 256'(1));
        latency(4, 2);
        wait_drain(4);
        send(4, 1'b1, 256'(V4), 256'(I4));
        idle(4);
        wait_drain(4);

        // 16 back-to-back alternating modes.
        t0 = $time;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) send(4, 1'b0, 256'(V4), 256'(F4));
            else            send(4, 1'b1, 256'(V4), 256'(I4));
        end
        chk("b2b_cycles", 256'(($time - t0) / 10), 256'(16));
        idle(4);
        wait_drain(4);

        // Back-pressure.
        bm[0] = 1'b0; be[0] = 256'(F4);
        bm[1] = 1'b1; be[1] = 256'(I4);
        bm[2] = 1'b0; be[2] = 256'(F4);
        bm[3] = 1'b1; be[3] = 256'(I4);
        b4.out_ready = 1'b0;
        j = 0;
        for (int c = 0; c < 4; c++) begin
            drive(4, 1'b1, bm[j], 256'(V4));
            @(negedge clk);
            if (b4.in_ready) begin
                push(4, be[j]);
                j++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 256'(j), 256'(2));
        chk("bp_occupancy", 256'(occ4), 256'(2));
        chk("bp_in_ready", 256'(b4.in_ready), 256'(0));
        chk("bp_out_valid", 256'(b4.out_valid), 256'(1));
        chk("bp_state_out", 256'(b4.state_out), 256'(F4));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_state", 256'(b4.state_out), 256'(F4));
        chk("bp_hold_valid", 256'(b4.out_valid), 256'(1));
        b4.out_ready = 1'b1;
        while (j < 4) begin
            send(4, bm[j], 256'(V4), be[j]);
            j++;
        end
        idle(4);
        wait_drain(4);

        // Flush with full pipeline and an offered state.
        b4.out_ready = 1'b0;
        send(4, 1'b0, 256'(V4), 256'(F4));
        send(4, 1'b1, 256'(V4), 256'(I4));
        chk("fl_occ_full", 256'(occ4), 256'(2));
        flush4 = 1'b1;
        drive(4, 1'b1, 1'b0, 256'(V4));
        @(negedge clk);
        chk("fl_in_ready", 256'(b4.in_ready), 256'(0));
        @(posedge clk);
        #1;
        flush4 = 1'b0;
        idle(4);
        chk("fl_occupancy", 256'(occ4), 256'(0));
        chk("fl_out_valid", 256'(b4.out_valid), 256'(0));
        q4.delete();
        b4.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset with full pipeline.
        b4.out_ready = 1'b0;
        send(4, 1'b0, 256'(V4), 256'(F4));
        send(4, 1'b1, 256'(V4), 256'(I4));
        idle(4);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 256'(b4.out_valid), 256'(0));
        chk("ar_occupancy", 256'(occ4), 256'(0));
        chk("ar_state_out", 256'(b4.state_out), 256'(0));
        q4.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        b4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(4, 1'b0, 256'(V4), 256'(F4));
        idle(4);
        latency(4, 2);
        wait_drain(4);

        // NB=8, STAGES=4.
        send(8, 1'b0, V8, F8);
        idle(8);
        latency(8, 4);
        wait_drain(8);
        send(8, 1'b1, V8, I8);
        send(8, 1'b0, V8, F8);
        idle(8);
        wait_drain(8);
        for (int k = 0; k < 3; k++) begin
            x = rand_state(8);
            y = ref_shift(8, 1'b0, x);
            send(8, 1'b0, x, y);
            send(8, 1'b1, y, x);
        end
        idle(8);
        wait_drain(8);
        b8.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            x = rand_state(8);
            send(8, 1'b1, x, ref_shift(8, 1'b1, x));
        end
        idle(8);
        chk("bp8_occupancy", 256'(occ8), 256'(4));
        chk("bp8_in_ready", 256'(b8.in_ready), 256'(0));
        b8.out_ready = 1'b1;
        wait_drain(8);

        // NB=6, STAGES=1.
        x = rand_state(6);
        send(6, 1'b0, x, ref_shift(6, 1'b0, x));
        idle(6);
        latency(6, 1);
        wait_drain(6);
        for (int k = 0; k < 4; k++) begin
            x = rand_state(6);
            y = ref_shift(6, 1'b0, x);
            send(6, 1'b0, x, y);
            send(6, 1'b1, y, x);
        end
        idle(6);
        wait_drain(6);

        chk("q4_empty", 256'(q4.size()), 256'(0));
        chk("q8_empty", 256'(q8.size()), 256'(0));
        chk("q6_empty", 256'(q6.size()), 256'(0));
        done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
